// File: rtl/csr_trap_ctrl.sv
// Trap/MRET sequencer: serialises mepc/mcause/mtval/mstatus writes into the CSR file, then redirects fetch.
// Interrupt acceptance is built only when CSR_TRAP_IRQ_EN is defined.
module csr_trap_ctrl #(
    parameter int unsigned CSR_ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          WRITE_ENABLE   = 1'b1,
    parameter bit          VECTORED       = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wb_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [DATA_WIDTH-1:0]     wb_wdata_i,
    output logic                      wb_ready_o,
    input  logic                      exc_valid_i,
    input  logic [31:0]               exc_cause_i,
    input  logic [31:0]               exc_pc_i,
    input  logic [31:0]               exc_tval_i,
    input  logic                      mret_i,
    input  logic [31:0]               int_pc_i,
    input  logic                      meip_i,
    input  logic                      mtip_i,
    input  logic [31:0]               mstatus_i,
    input  logic [31:0]               mie_i,
    input  logic [31:0]               mtvec_i,
    input  logic [31:0]               mepc_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      redirect_valid_o,
    output logic [31:0]               redirect_pc_o,
    output logic                      busy_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_MEPC    = 3'd1;
    localparam logic [2:0] W_MCAUSE  = 3'd2;
    localparam logic [2:0] W_MTVAL   = 3'd3;
    localparam logic [2:0] W_MSTATUS = 3'd4;
    localparam logic [2:0] M_STATUS  = 3'd5;
    localparam logic [2:0] REDIRECT  = 3'd6;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, pc_q, tval_q;
    logic        irq_q, mret_q;

    logic        irq_take;
    logic [31:0] irq_cause;

`ifdef CSR_TRAP_IRQ_EN
    logic irq_ext, irq_tim;
    assign irq_ext   = meip_i & mie_i[11];
    assign irq_tim   = mtip_i & mie_i[7];
    assign irq_take  = mstatus_i[3] & (irq_ext | irq_tim);
    assign irq_cause = irq_ext ? 32'h8000_000B : 32'h8000_0007;
`else
    logic unused_irq;
    assign unused_irq = ^{meip_i, mtip_i, mie_i};
    assign irq_take   = 1'b0;
    assign irq_cause  = '0;
`endif

    logic exc_acc, mret_acc, irq_acc;
    assign exc_acc  = exc_valid_i;
    assign mret_acc = mret_i & ~exc_valid_i;
    assign irq_acc  = irq_take & ~exc_valid_i & ~mret_i;

    logic [31:0] trap_mstatus, mret_mstatus, trap_target;

    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = mstatus_i;
        mret_mstatus[3]     = mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
        trap_target         = {mtvec_i[31:2], 2'b00};
        if (VECTORED && irq_q && (mtvec_i[1:0] == 2'b01))
            trap_target = trap_target + {cause_q[29:0], 2'b00};
    end

    logic                      we;
    logic [CSR_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      redir;
    logic [31:0]               redir_pc;
    logic                      ready;

    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        redir    = 1'b0;
        redir_pc = '0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_acc || irq_acc) state_d = W_MEPC;
                else if (mret_acc)      state_d = M_STATUS;
                else begin
                    ready = 1'b1;
                    we    = wb_we_i;
                    waddr = wb_waddr_i;
                    wdata = wb_wdata_i;
                end
            end
            W_MEPC: begin
                state_d = W_MCAUSE;
                we      = 1'b1;
                waddr   = CSR_ADDR_WIDTH'(ADDR_MEPC);
                wdata   = DATA_WIDTH'(pc_q);
            end
            W_MCAUSE: begin
                state_d = W_MTVAL;
                we      = 1'b1;
                waddr   = CSR_ADDR_WIDTH'(ADDR_MCAUSE);
                wdata   = DATA_WIDTH'(cause_q);
            end
            W_MTVAL: begin
                state_d = W_MSTATUS;
                we      = 1'b1;
                waddr   = CSR_ADDR_WIDTH'(ADDR_MTVAL);
                wdata   = DATA_WIDTH'(tval_q);
            end
            W_MSTATUS: begin
                state_d = REDIRECT;
                we      = 1'b1;
                waddr   = CSR_ADDR_WIDTH'(ADDR_MSTATUS);
                wdata   = DATA_WIDTH'(trap_mstatus);
            end
            M_STATUS: begin
                state_d = REDIRECT;
                we      = 1'b1;
                waddr   = CSR_ADDR_WIDTH'(ADDR_MSTATUS);
                wdata   = DATA_WIDTH'(mret_mstatus);
            end
            REDIRECT: begin
                state_d  = IDLE;
                redir    = 1'b1;
                redir_pc = mret_q ? pc_q : trap_target;
            end
            default: state_d = IDLE;
        endcase
        // Reset masks outputs in the same cycle so an aborted sequence emits nothing further.
        if (rst_i || !we) begin
            waddr = '0;
            wdata = '0;
        end
        if (rst_i) begin
            we       = 1'b0;
            redir    = 1'b0;
            redir_pc = '0;
            ready    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            irq_q   <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (exc_acc) begin
                    cause_q <= exc_cause_i;
                    pc_q    <= exc_pc_i;
                    tval_q  <= exc_tval_i;
                    irq_q   <= 1'b0;
                    mret_q  <= 1'b0;
                end else if (mret_acc) begin
                    pc_q   <= mepc_i;
                    irq_q  <= 1'b0;
                    mret_q <= 1'b1;
                end else if (irq_acc) begin
                    cause_q <= irq_cause;
                    pc_q    <= int_pc_i;
                    tval_q  <= '0;
                    irq_q   <= 1'b1;
                    mret_q  <= 1'b0;
                end
            end
        end
    end

    assign csr_we_o         = we ? WRITE_ENABLE : ~WRITE_ENABLE;
    assign csr_waddr_o      = waddr;
    assign csr_wdata_o      = wdata;
    assign redirect_valid_o = redir;
    assign redirect_pc_o    = redir_pc;
    assign wb_ready_o       = ready;
    assign busy_o           = (state_q != IDLE) && !rst_i;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: exception, MRET, collision, reset abort and interrupt paths.
module tb_csr_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_we_i;
    logic [11:0] wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_ready_o;
    logic        exc_valid_i;
    logic [31:0] exc_cause_i, exc_pc_i, exc_tval_i;
    logic        mret_i;
    logic [31:0] int_pc_i;
    logic        meip_i, mtip_i;
    logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    csr_trap_ctrl #(.CSR_ADDR_WIDTH(12), .DATA_WIDTH(32), .WRITE_ENABLE(1'b1), .VECTORED(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_ready_o(wb_ready_o),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .int_pc_i(int_pc_i), .meip_i(meip_i), .mtip_i(mtip_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow a short settle.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic chk_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
        chk({tag, "_we"}, 32'(csr_we_o), 32'd1);
        chk({tag, "_addr"}, 32'(csr_waddr_o), 32'(addr));
        chk({tag, "_data"}, csr_wdata_o, data);
        chk({tag, "_redir"}, 32'(redirect_valid_o), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_redir"}, 32'(redirect_valid_o), 32'd0);
        chk({tag, "_rpc"}, redirect_pc_o, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        exc_valid_i = 1'b0; exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0;
        mret_i = 1'b0; int_pc_i = '0; meip_i = 1'b0; mtip_i = 1'b0;
        mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;

        // Reset state
        tick; tick; settle;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_we", 32'(csr_we_o), 32'd0);
        chk("rst_redir", 32'(redirect_valid_o), 32'd0);
        tick; rst_i = 1'b0; settle;
        chk_idle("post_rst");
        chk("post_rst_ready", 32'(wb_ready_o), 32'd1);
        chk("post_rst_addr0", 32'(csr_waddr_o), 32'd0);

        // Exception colliding with an mscratch write: write dropped, sequence T+1..T+6
        tick;
        exc_valid_i = 1'b1; exc_cause_i = 32'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
        mtvec_i = 32'h200; mstatus_i = 32'h8;
        wb_we_i = 1'b1; wb_waddr_i = 12'h340; wb_wdata_i = 32'h55; settle;
        chk("exc_t_we", 32'(csr_we_o), 32'd0);
        chk("exc_t_ready", 32'(wb_ready_o), 32'd0);
        chk("exc_t_busy", 32'(busy_o), 32'd0);
        tick; exc_valid_i = 1'b0; exc_pc_i = 32'h999; exc_tval_i = 32'h0; wb_we_i = 1'b0; settle;
        chk_write("exc_mepc", 12'h341, 32'h100);
        chk("exc_busy1", 32'(busy_o), 32'd1);
        chk("exc_ready1", 32'(wb_ready_o), 32'd0);
        tick; settle; chk_write("exc_mcause", 12'h342, 32'd2);
        tick; settle; chk_write("exc_mtval", 12'h343, 32'hDEAD);
        tick; settle; chk_write("exc_mstatus", 12'h300, 32'h1880);
        tick; settle;
        chk("exc_redir", 32'(redirect_valid_o), 32'd1);
        chk("exc_rpc", redirect_pc_o, 32'h200);
        chk("exc_redir_we", 32'(csr_we_o), 32'd0);
        chk("exc_redir_busy", 32'(busy_o), 32'd1);
        tick; settle;
        chk_idle("exc_done");

        // Re-presented write passes through combinationally
        wb_we_i = 1'b1; wb_waddr_i = 12'h340; wb_wdata_i = 32'h55; #1;
        chk("pass_ready", 32'(wb_ready_o), 32'd1);
        chk_write("pass", 12'h340, 32'h55);

        // MRET with a coincident write held off
        tick; mret_i = 1'b1; mstatus_i = 32'h1880; mepc_i = 32'h104; settle;
        chk("mret_t_ready", 32'(wb_ready_o), 32'd0);
        chk("mret_t_we", 32'(csr_we_o), 32'd0);
        tick; mret_i = 1'b0; mepc_i = 32'h999; wb_we_i = 1'b0; settle;
        chk_write("mret_mstatus", 12'h300, 32'h1888);
        chk("mret_busy1", 32'(busy_o), 32'd1);
        tick; settle;
        chk("mret_redir", 32'(redirect_valid_o), 32'd1);
        chk("mret_rpc", redirect_pc_o, 32'h104);
        chk("mret_busy2", 32'(busy_o), 32'd1);
        tick; settle;
        chk_idle("mret_done");

        // Exception beats MRET; reset during W_MTVAL aborts the rest
        mstatus_i = 32'h8;
        tick; exc_valid_i = 1'b1; mret_i = 1'b1; exc_pc_i = 32'h180; exc_cause_i = 32'd5; exc_tval_i = 32'h77;
        tick; exc_valid_i = 1'b0; mret_i = 1'b0; settle;
        chk_write("prio_mepc", 12'h341, 32'h180);
        tick; tick; rst_i = 1'b1; settle;
        chk("rst_mtval_we", 32'(csr_we_o), 32'd0);
        chk("rst_mtval_busy", 32'(busy_o), 32'd0);
        tick; rst_i = 1'b0; settle;
        chk_idle("abort1");
        chk("abort1_we", 32'(csr_we_o), 32'd0);
        tick; settle; chk_idle("abort2");
        chk("abort2_we", 32'(csr_we_o), 32'd0);
        tick; settle; chk_idle("abort3");

        // Interrupt path
`ifdef CSR_TRAP_IRQ_EN
        tick; mtvec_i = 32'h201; mie_i = 32'h80; mtip_i = 1'b1; mstatus_i = 32'h8; int_pc_i = 32'h300; settle;
        chk("irq_t_ready", 32'(wb_ready_o), 32'd0);
        tick; mtip_i = 1'b0; settle; chk_write("irq_mepc", 12'h341, 32'h300);
        tick; settle; chk_write("irq_mcause", 12'h342, 32'h8000_0007);
        tick; settle; chk_write("irq_mtval", 12'h343, 32'h0);
        tick; settle; chk_write("irq_mstatus", 12'h300, 32'h1880);
        tick; settle;
        chk("irq_redir", 32'(redirect_valid_o), 32'd1);
        chk("irq_rpc", redirect_pc_o, 32'h21C);
        tick; settle; chk_idle("irq_done");
`else
        tick; meip_i = 1'b1; mie_i = 32'h880; mstatus_i = 32'h8; settle;
        chk("noirq_ready", 32'(wb_ready_o), 32'd1);
        tick; settle; chk_idle("noirq1");
        tick; settle; chk_idle("noirq2");
        meip_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
